seg_bcd_encoder: RTL and testbench



---
 rtl/seg_bcd_encoder.sv | 132 +++++++++++++
 tb/tb_seg_bcd_encoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_bcd_encoder.sv
// Two-digit BCD display encoder: accepts a 7-bit value over valid/ready, converts it
// with a sequential double-dabble engine and holds the packed seven-segment word.
module seg_bcd_encoder #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [6:0]  in_value,
  output logic        in_ready,
  output logic [13:0] both7seg,
  output logic        out_valid
);

  localparam int unsigned VAL_W = 7;
  localparam int unsigned BCD_W = 8;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VAL_W - 1);
  localparam logic [VAL_W-1:0] MAX_SHOWN  = VAL_W'(99);
  localparam logic [SEG_W-1:0] SEG_DASH   = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK  = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ENCODE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [VAL_W-1:0]     sh_q, sh_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 in_ready_q, in_ready_d;
  logic [2*SEG_W-1:0]   both7seg_q, both7seg_d;
  logic                 out_valid_q, out_valid_d;

  // Segment order g,f,e,d,c,b,a, active-high.
  function automatic logic [SEG_W-1:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = SEG_DASH;
    endcase
  endfunction

  // Nibble correction stays within 4 bits; no carry into the neighbour.
  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    both7seg_d  = both7seg_q;
    out_valid_d = 1'b0;
    bcd_adj     = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sh_d    = in_value;
          bcd_d   = '0;
          ovf_d   = (in_value > MAX_SHOWN);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
        if (cnt_q == LAST_SHIFT) begin
          state_d = ENCODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ENCODE: begin
        if (ovf_q) begin
          both7seg_d = {SEG_DASH, SEG_DASH};
        end else begin
          both7seg_d[6:0]  = seg_of(bcd_q[3:0]);
          both7seg_d[13:7] = (BLANK_LZ && (bcd_q[7:4] == 4'd0)) ? SEG_BLANK : seg_of(bcd_q[7:4]);
        end
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      both7seg_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      both7seg_q  <= both7seg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign both7seg  = both7seg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seg_bcd_encoder.sv
// Bench for seg_bcd_encoder: decimal-arithmetic reference model checked every cycle
// against two instances (leading-zero blanking on and off), plus literal vectors.
module tb_seg_bcd_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [6:0]  in_value = '0;
  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [13:0] seg1, seg0;

  int errors = 0;
  int checks = 0;

  seg_bcd_encoder #(.BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready1), .both7seg(seg1), .out_valid(out_valid1));

  seg_bcd_encoder #(.BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready0), .both7seg(seg0), .out_valid(out_valid0));

  always #5 clk = ~clk;

  function automatic logic [6:0] digit(input int d);
    case (d)
      0: digit = 7'h3F; 1: digit = 7'h06; 2: digit = 7'h5B; 3: digit = 7'h4F;
      4: digit = 7'h66; 5: digit = 7'h6D; 6: digit = 7'h7D; 7: digit = 7'h07;
      8: digit = 7'h7F; default: digit = 7'h6F;
    endcase
  endfunction

  function automatic logic [13:0] exp_seg(input int v, input bit blank);
    int t, o;
    if (v > 99) return {7'h40, 7'h40};
    t = v / 10;
    o = v % 10;
    return {(blank && t == 0) ? 7'h00 : digit(t), digit(o)};
  endfunction

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: accepted value reappears as decimal digits 8 edges after the transfer.
  bit          chk_en = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_ov = 1'b0;
  logic [13:0] m_seg1 = '0, m_seg0 = '0;
  int          m_cnt = 0;
  int          m_val = 0;
  int          xfers = 0;

  always @(posedge clk) begin
    m_ov = 1'b0;
    if (rst) begin
      chk_en  = 1'b1;
      m_ready = 1'b1;
      m_seg1  = '0;
      m_seg0  = '0;
      m_cnt   = 0;
    end else if (m_ready) begin
      if (in_valid) begin
        m_val   = int'(in_value);
        m_cnt   = 8;
        m_ready = 1'b0;
        xfers++;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_seg1  = exp_seg(m_val, 1'b1);
        m_seg0  = exp_seg(m_val, 1'b0);
        m_ov    = 1'b1;
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready1", 14'(in_ready1), 14'(m_ready));
      chk("ready0", 14'(in_ready0), 14'(m_ready));
      chk("ovalid1", 14'(out_valid1), 14'(m_ov));
      chk("ovalid0", 14'(out_valid0), 14'(m_ov));
      chk("seg1", seg1, m_seg1);
      chk("seg0", seg0, m_seg0);
    end
  end

  task automatic send(input logic [6:0] v, input logic [13:0] e1, input logic [13:0] e0,
                      input bit hold, input logic [6:0] nv, output int lowcnt);
    int x0;
    bit got;
    x0 = xfers;
    lowcnt = 0;
    in_valid = 1'b1;
    in_value = v;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (xfers != x0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout got=none exp=transfer of %0d", v);
      in_valid = 1'b0;
      return;
    end
    if (hold) in_value = nv;
    else begin
      in_valid = 1'b0;
      in_value = ~v;
    end
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (out_valid1) got = 1'b1;
      else begin
        if (!in_ready1) lowcnt++;
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ovalid_timeout got=none exp=pulse for %0d", v);
      return;
    end
    chk($sformatf("lit1_%0d", v), seg1, e1);
    chk($sformatf("lit0_%0d", v), seg0, e0);
  endtask

  initial begin
    int lc;
    int pulses;
    // Reset held two cycles with a pending request: nothing accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    in_value = 7'd42;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_seg", seg1, 14'h0000);
    chk("rst_ovalid", 14'(out_valid1), 14'd0);
    chk("rst_ready", 14'(in_ready1), 14'd1);
    repeat (3) @(negedge clk);
    chk("rst_idle_ready", 14'(in_ready1), 14'd1);

    send(7'd42, {7'h66, 7'h5B}, {7'h66, 7'h5B}, 1'b0, 7'd0, lc);
    chk("ready_low_cycles", 14'(lc), 14'd8);
    repeat (2) @(negedge clk);

    send(7'd7,   {7'h00, 7'h07}, {7'h3F, 7'h07}, 1'b0, 7'd0, lc);
    send(7'd0,   {7'h00, 7'h3F}, {7'h3F, 7'h3F}, 1'b0, 7'd0, lc);
    send(7'd5,   {7'h00, 7'h6D}, {7'h3F, 7'h6D}, 1'b0, 7'd0, lc);
    send(7'd99,  {7'h6F, 7'h6F}, {7'h6F, 7'h6F}, 1'b0, 7'd0, lc);
    send(7'd100, {7'h40, 7'h40}, {7'h40, 7'h40}, 1'b0, 7'd0, lc);
    send(7'd127, {7'h40, 7'h40}, {7'h40, 7'h40}, 1'b0, 7'd0, lc);
    send(7'd10,  {7'h06, 7'h3F}, {7'h06, 7'h3F}, 1'b0, 7'd0, lc);

    // Back-to-back with in_valid held throughout.
    send(7'd13, {7'h06, 7'h4F}, {7'h06, 7'h4F}, 1'b1, 7'd86, lc);
    send(7'd86, {7'h7F, 7'h7D}, {7'h7F, 7'h7D}, 1'b0, 7'd0, lc);
    repeat (3) @(negedge clk);

    // Reset on edge N+3 aborts the conversion.
    begin
      int x0;
      bit got;
      x0 = xfers;
      in_valid = 1'b1;
      in_value = 7'd55;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        if (xfers != x0) got = 1'b1;
      end
      in_valid = 1'b0;
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL abort_xfer_timeout got=none exp=transfer");
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_seg", seg1, 14'h0000);
      chk("abort_ready", 14'(in_ready1), 14'd1);
      chk("abort_ovalid", 14'(out_valid1), 14'd0);
      pulses = 0;
      repeat (12) begin
        @(negedge clk);
        if (out_valid1) pulses++;
      end
      chk("abort_no_pulse", 14'(pulses), 14'd0);
    end

    send(7'd55, {7'h6D, 7'h6D}, {7'h6D, 7'h6D}, 1'b0, 7'd0, lc);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
